// File: rtl/blink_period_meter_pkg.sv
// Shared definitions for the blink period meter: FSM state type, default
// parameter values for a 50 MHz clock, and a small saturating helper.
package blink_period_meter_pkg;

  typedef enum logic {
    ST_WAIT_EDGE = 1'b0,
    ST_MEASURE   = 1'b1
  } state_e;

  localparam int unsigned DEF_CNT_W      = 26;
  localparam int unsigned DEF_TIMEOUT    = 50_000_000;
  localparam int unsigned DEF_EXP_PERIOD = 25_000_001;

  // a - b, clamped at zero (lower in_range bound must not wrap)
  function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : 0;
  endfunction

endpackage

// File: rtl/sync_rise_det.sv
// Synchronizer plus rising-edge detector for a slow asynchronous input.
// Ports:
//   clk     - system clock
//   reset   - synchronous, active-high reset
//   d_async - asynchronous input
//   level   - synchronized level (last synchronizer stage)
//   rise    - high for one cycle when level goes 0 -> 1
module sync_rise_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_async,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   edge_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_async};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~edge_q;

endmodule

// File: rtl/blink_period_meter.sv
// Measures period (rise to rise) and high time of a slow square wave in clk
// cycles, flags whether the period is within EXP_PERIOD +/- TOL, and reports
// a stalled input when no rising edge arrives within TIMEOUT cycles.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   sig_in       - asynchronous square wave under measurement
//   period       - last measured period
//   high_time    - high cycles within that period
//   meas_valid   - one-cycle pulse when period/high_time update
//   in_range     - period within tolerance, updated with meas_valid
//   timeout      - one-cycle pulse on stall
//   locked       - high while measuring
//   stuck_level  - synchronized input level captured at the last timeout
module blink_period_meter
  import blink_period_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter int unsigned EXP_PERIOD  = DEF_EXP_PERIOD,
  parameter int unsigned TOL         = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             in_range,
  output logic             timeout,
  output logic             locked,
  output logic             stuck_level
);

  // One bit wider than the counters so the bounds never wrap.
  localparam int unsigned      CW1        = CNT_W + 1;
  localparam logic [CNT_W:0]   RANGE_LO   = CW1'(sat_sub(EXP_PERIOD, TOL));
  localparam logic [CNT_W:0]   RANGE_HI   = CW1'(EXP_PERIOD + TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  logic level, rise;

  sync_rise_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .d_async(sig_in),
    .level  (level),
    .rise   (rise)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             mv_q, mv_d;
  logic             inr_q, inr_d;
  logic             to_q, to_d;
  logic             stuck_q, stuck_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_WAIT_EDGE;
      cnt_q    <= '0;
      hi_q     <= '0;
      period_q <= '0;
      high_q   <= '0;
      mv_q     <= 1'b0;
      inr_q    <= 1'b0;
      to_q     <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      period_q <= period_d;
      high_q   <= high_d;
      mv_q     <= mv_d;
      inr_q    <= inr_d;
      to_q     <= to_d;
      stuck_q  <= stuck_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    period_d = period_q;
    high_d   = high_q;
    mv_d     = 1'b0;
    inr_d    = inr_q;
    to_d     = 1'b0;
    stuck_d  = stuck_q;
    case (state_q)
      ST_WAIT_EDGE: begin
        if (rise) begin
          cnt_d   = ONE;
          hi_d    = ONE;
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        // A rise on the same cycle as cnt==TIMEOUT is a valid measurement.
        if (rise) begin
          period_d = cnt_q;
          high_d   = hi_q;
          mv_d     = 1'b1;
          inr_d    = ({1'b0, cnt_q} >= RANGE_LO) && ({1'b0, cnt_q} <= RANGE_HI);
          cnt_d    = ONE;
          hi_d     = ONE;
        end else if (cnt_q == TIMEOUT_C) begin
          to_d     = 1'b1;
          stuck_d  = level;
          state_d  = ST_WAIT_EDGE;
        end else begin
          cnt_d    = cnt_q + ONE;
          hi_d     = hi_q + CNT_W'(level);
        end
      end
      default: state_d = ST_WAIT_EDGE;
    endcase
  end

  assign period      = period_q;
  assign high_time   = high_q;
  assign meas_valid  = mv_q;
  assign in_range    = inr_q;
  assign timeout     = to_q;
  assign locked      = (state_q == ST_MEASURE);
  assign stuck_level = stuck_q;

endmodule

// File: tb/tb_blink_period_meter.sv
module tb_blink_period_meter;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 64;
  localparam int EXP     = 20;
  localparam int TOL     = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic             meas_valid, in_range, timeout, locked, stuck_level;

  int checks = 0;
  int errors = 0;

  blink_period_meter #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT),
    .EXP_PERIOD (EXP),
    .TOL        (TOL),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sig_in     (sig_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .in_range   (in_range),
    .timeout    (timeout),
    .locked     (locked),
    .stuck_level(stuck_level)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: input seen by the measuring logic three edges after it
  // is sampled; period/high time derived from edge-count differences.
  bit p1, p2, p3, r;
  bit model_ok = 0;
  bit m_locked, m_mv, m_inr, m_to, m_stuck;
  int m_period, m_high, k, ones, rise_t, ones_at_rise, diff;

  always @(posedge clk) begin
    if (reset) begin
      p1 = 0; p2 = 0; p3 = 0;
      m_locked = 0; m_mv = 0; m_inr = 0; m_to = 0; m_stuck = 0;
      m_period = 0; m_high = 0; k = 0; ones = 0; rise_t = 0; ones_at_rise = 0;
      model_ok = 1;
    end else begin
      r = p2 && !p3;
      m_mv = 0;
      m_to = 0;
      if (!m_locked) begin
        if (r) begin
          m_locked = 1; rise_t = k; ones_at_rise = ones;
        end
      end else if (r) begin
        m_period = k - rise_t;
        m_high   = ones - ones_at_rise;
        diff     = (m_period > EXP) ? m_period - EXP : EXP - m_period;
        m_inr    = (diff <= TOL);
        m_mv     = 1;
        rise_t = k; ones_at_rise = ones;
      end else if (k - rise_t == TIMEOUT) begin
        m_to = 1; m_stuck = p2; m_locked = 0;
      end
      ones += int'(p2);
      k++;
      p3 = p2; p2 = p1; p1 = sig_in;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("period", period, m_period);
      check("high_time", high_time, m_high);
      check("meas_valid", meas_valid, m_mv);
      check("in_range", in_range, m_inr);
      check("timeout", timeout, m_to);
      check("locked", locked, m_locked);
      check("stuck_level", stuck_level, m_stuck);
    end
  end

  task automatic wave(input int hi, input int lo);
    sig_in = 1'b1;
    repeat (hi) @(negedge clk);
    sig_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // Waits (bounded) for the measurement triggered by a rise just driven.
  task automatic check_next_meas(input string nm, input int ep, input int eh, input int er);
    bit seen;
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (meas_valid) begin
        seen = 1;
        check({nm, "_period"}, period, ep);
        check({nm, "_high"}, high_time, eh);
        check({nm, "_in_range"}, in_range, er);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_meas_valid got none expected pulse within 6 cycles", nm);
    end
  endtask

  int hi_r, lo_r;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_period", period, 0);
    check("rst_locked", locked, 0);
    check("rst_mv", meas_valid, 0);
    reset = 1'b0;

    // steady 20-cycle wave
    repeat (4) wave(8, 12);
    sig_in = 1'b1;
    check_next_meas("t1", 20, 8, 1);
    repeat (5) @(negedge clk);
    sig_in = 1'b0;
    repeat (12) @(negedge clk);

    // period 25, then 18 (lower tolerance boundary)
    repeat (3) wave(10, 15);
    sig_in = 1'b1;
    check_next_meas("t2a", 25, 10, 0);
    repeat (7) @(negedge clk);
    sig_in = 1'b0;
    repeat (8) @(negedge clk);
    wave(8, 10);
    sig_in = 1'b1;
    check_next_meas("t2b", 18, 8, 1);
    repeat (5) @(negedge clk);
    sig_in = 1'b0;
    repeat (10) @(negedge clk);

    // rise exactly TIMEOUT cycles after the previous one
    wave(30, 34);
    sig_in = 1'b1;
    check_next_meas("t4", 64, 30, 0);

    // input stuck high -> timeout, old result kept
    repeat (80) @(negedge clk);
    check("t3_stuck", stuck_level, 1);
    check("t3_locked", locked, 0);
    check("t3_period_kept", period, 64);
    sig_in = 1'b0;
    repeat (10) @(negedge clk);
    repeat (3) wave(8, 12);

    // latency from input edge and a one-cycle glitch
    sig_in = 1'b1;
    @(negedge clk);
    sig_in = 1'b0;
    @(negedge clk);
    check("t6_early", meas_valid, 0);
    @(negedge clk);
    check("t6_latency", meas_valid, 1);
    repeat (16) @(negedge clk);
    sig_in = 1'b1;
    check_next_meas("t6_glitch", 19, 1, 1);
    repeat (5) @(negedge clk);
    sig_in = 1'b0;
    repeat (10) @(negedge clk);

    // reset mid-period
    sig_in = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t5_period", period, 0);
    check("t5_high", high_time, 0);
    check("t5_locked", locked, 0);
    check("t5_in_range", in_range, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    sig_in = 1'b0;
    repeat (10) @(negedge clk);
    repeat (2) wave(8, 12);

    // randomized waves, occasional reset, occasional exact-TIMEOUT period
    for (int n = 0; n < 150; n++) begin
      hi_r = int'($urandom_range(1, 40));
      lo_r = int'($urandom_range(1, 45));
      if ($urandom_range(0, 9) == 0) lo_r = TIMEOUT - hi_r;
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      wave(hi_r, lo_r);
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
